uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per requester FIFO; power of two, minimum 2.
REQ-002 Parameter BUSY_TIMEOUT, default 16, maximum cycles allowed from a tx_send pulse to the tx_busy rising edge.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers a byte.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 FIFO can accept a byte.
REQ-008 req1_valid, req1_data, req1_ready: same widths and meanings as REQ-005..007, for requester 1.
REQ-009 tx_data  output  8  byte presented to the downstream serializer.
REQ-010 tx_send  output  1  one-cycle launch pulse to the serializer.
REQ-011 tx_busy  input  1  serializer busy flag.
REQ-012 grant_id  output  1  requester owning the current transfer.
REQ-013 sched_busy  output  1  a transfer is in progress (state not IDLE).
REQ-014 fifo0_count, fifo1_count  output  clog2(FIFO_DEPTH)+1 each  FIFO occupancy.
REQ-015 err_timeout  output  1  sticky timeout flag.
REQ-016 err_clr  input  1  clears err_timeout.

Function
REQ-017 A byte is pushed into FIFOn when reqn_valid && reqn_ready; reqn_ready SHALL equal (fifon_count < FIFO_DEPTH).
REQ-018 Each FIFO SHALL be FIFO-ordered, with pointers wrapping modulo FIFO_DEPTH.
- Push and pop of the same FIFO in one cycle: count unchanged.
- Push while full: impossible, since ready=0.
REQ-019 State machine SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE, both FIFOs empty: SHALL stay in IDLE.
REQ-021 IDLE, one FIFO non-empty: SHALL pop that FIFO's head into tx_data, set grant_id, and go to ISSUE.
REQ-022 IDLE, both FIFOs non-empty: SHALL grant round-robin, serving the requester that is not last_grant; last_grant resets to 1, so requester 0 wins the first contention.
REQ-023 ISSUE: SHALL assert tx_send for exactly one cycle, clear the timer, and go to WAIT_BUSY; tx_data SHALL be held stable from ISSUE until the exit from WAIT_DONE.
REQ-024 WAIT_BUSY, tx_busy=1: SHALL go to WAIT_DONE.
REQ-025 WAIT_BUSY, tx_busy=0: SHALL increment the timer; on the cycle the timer reaches BUSY_TIMEOUT-1, SHALL set err_timeout, drop the byte, and go to IDLE.
REQ-026 WAIT_DONE, tx_busy=0: SHALL set last_grant=grant_id and go to IDLE.
REQ-027 Minimum spacing between consecutive tx_send pulses SHALL be the serializer busy time plus 3 cycles.
REQ-028 err_timeout SHALL be sticky, cleared only by err_clr or reset; set and clear in the same cycle: set wins.
REQ-029 FIFO pushes SHALL proceed in every state, independent of the scheduler.
REQ-030 sched_busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 While reset is high, the following SHALL be held at their reset values, including during a transfer in progress:
- state=IDLE, tx_send=0, tx_data=8'h00, grant_id=0, last_grant=1
- FIFO pointers and counts = 0, err_timeout=0, timer=0
REQ-032 The first edge after reset release SHALL operate normally; no spurious tx_send SHALL follow release.

Verification
REQ-033 Single byte: push 8'hA5 on req0, serializer model busy=1 for 10 cycles -> one tx_send with tx_data=A5, grant_id=0, sched_busy back to 0 one cycle after busy falls.
REQ-034 Contention: preload 3 bytes in each FIFO (0x10-0x12, 0x20-0x22) -> launch order 10,20,11,21,12,22.
REQ-035 Full FIFO: push 5 bytes to req0 with the serializer stalled -> req0_ready=0 after the 4th push, fifo0_count=4; 5th byte accepted only after the first pop.
REQ-036 Timeout: tx_busy tied 0 -> err_timeout=1 at cycle BUSY_TIMEOUT after ISSUE, byte dropped, next byte issued; err_clr=1 -> flag 0.
REQ-037 Reset mid-transfer: assert reset in WAIT_DONE -> tx_send=0, counts=0, sched_busy=0 immediately; post-release push of 0x3C transmits normally.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two requester byte FIFOs arbitrated round-robin into a single UART serializer,
// with a launch/busy handshake and a sticky timeout when the serializer never responds.
module uart_tx_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic [7:0]                    req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [7:0]                    req1_data,
  output logic                          req1_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic                          grant_id,
  output logic                          sched_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo0_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo1_count,
  output logic                          err_timeout,
  input  logic                          err_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [2][FIFO_DEPTH];
  logic [1:0][PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][7:0] req_data;
  logic [1:0] req_valid, ready, push, pop, avail;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_send_q, tx_send_d, grant_q, grant_d, last_q, last_d, busy_q, busy_d, err_q, err_d, pick;
  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};
  assign ready = {cnt_q[1] < CW'(FIFO_DEPTH), cnt_q[0] < CW'(FIFO_DEPTH)};
  assign avail = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign push  = req_valid & ready;
  // Under contention serve whoever did not complete the last transfer.
  assign pick  = &avail ? ~last_q : ~avail[0];
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    err_d     = err_q & ~err_clr;
    pop       = '0;
    case (state_q)
      IDLE: if (|avail) begin
        pop[pick] = 1'b1;
        tx_data_d = mem_q[pick][rd_q[pick]];
        grant_d   = pick;
        state_d   = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      else begin
        timer_d = timer_q + TW'(1);
        if (timer_d == TW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: if (!tx_busy) begin
        last_d  = grant_q;
        state_d = IDLE;
      end
    endcase
    for (int n = 0; n < 2; n++) begin
      wr_d[n]  = wr_q[n] + PW'(push[n]);
      rd_d[n]  = rd_q[n] + PW'(pop[n]);
      cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
    end
    tx_send_d = state_d == ISSUE;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk)
    for (int n = 0; n < 2; n++)
      if (push[n]) mem_q[n][wr_q[n]] <= req_data[n];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign fifo0_count = cnt_q[0];
  assign fifo1_count = cnt_q[1];
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign grant_id    = grant_q;
  assign sched_busy  = busy_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a queue-based
// transaction model and a clocked serializer model.
module tb_uart_tx_sched;
  localparam int DEPTH = 4;
  localparam int BT    = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, tx_send, grant_id, sched_busy, err_timeout;
  logic [7:0] tx_data;
  logic [2:0] fifo0_count, fifo1_count;
  logic tx_busy = 1'b0, err_clr = 1'b0;
  int checks = 0, failures = 0;
  bit stall = 1'b0;
  int busy_len = 4;
  logic [7:0] q0[$], q1[$], log_q[$];
  logic [7:0] cur_b;
  int cyc = 0, s0 = 0, s1 = 0, send_cyc = 0, cur_len = 0;
  bit in_xfer = 0, cur_to = 0, last_m = 1, err_m = 0, data_bad = 0, cur_g = 0, exp_g = 0;
  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy), .grant_id(grant_id),
    .sched_busy(sched_busy), .fifo0_count(fifo0_count), .fifo1_count(fifo1_count),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Serializer: busy rises on the edge after the launch and stays high for busy_len cycles.
  initial begin
    int len;
    forever begin
      @(negedge clk);
      if (tx_send && !reset && !stall) begin
        len = busy_len;
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end
  // Transaction model: per-requester queues, round-robin on who completed last.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_send", tx_send, 0);
      chk("rst_busy", sched_busy, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_cnt0", fifo0_count, 0);
      chk("rst_cnt1", fifo1_count, 0);
      chk("rst_err", err_timeout, 0);
      q0.delete(); q1.delete();
      s0 = 0; s1 = 0; in_xfer = 0; last_m = 1; err_m = 0;
    end else begin
      if (in_xfer && tx_data !== cur_b) data_bad = 1;
      if (tx_send) begin
        chk("overlap", in_xfer, 0);
        if (s0 == 0 && s1 == 0) chk("spurious_send", tx_send, 0);
        else begin
          exp_g = (s0 != 0 && s1 != 0) ? !last_m : (s0 == 0);
          cur_b = exp_g ? q1.pop_front() : q0.pop_front();
          chk("grant", grant_id, exp_g);
          chk("tx_data", tx_data, cur_b);
          log_q.push_back(tx_data);
          in_xfer = 1; cur_g = exp_g; cur_to = stall; cur_len = busy_len;
          send_cyc = cyc; data_bad = 0;
        end
      end else if (in_xfer && !sched_busy) begin
        chk("xfer_len", cyc - send_cyc, cur_to ? BT : cur_len + 2);
        chk("data_hold", data_bad, 0);
        if (!cur_to) last_m = cur_g;
        in_xfer = 0;
      end
      chk("err", err_timeout, err_m);
      chk("cnt0", fifo0_count, q0.size());
      chk("cnt1", fifo1_count, q1.size());
      chk("rdy0", req0_ready, q0.size() < DEPTH);
      chk("rdy1", req1_ready, q1.size() < DEPTH);
      s0 = q0.size(); s1 = q1.size();
      if (req0_valid && s0 < DEPTH) q0.push_back(req0_data);
      if (req1_valid && s1 < DEPTH) q1.push_back(req1_data);
      err_m = (in_xfer && cur_to && cyc == send_cyc + BT - 1) || (err_m && !err_clr);
    end
  end
  task automatic push(input bit id, input logic [7:0] b);
    int n = 0;
    bit ok;
    if (id) begin req1_valid = 1'b1; req1_data = b; end
    else begin req0_valid = 1'b1; req0_data = b; end
    do begin
      @(negedge clk); ok = id ? req1_ready : req0_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    chk("push_accept", ok, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask
  task automatic wait_send(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tx_send && n < 300);
    chk(tag, tx_send, 1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sched_busy || fifo0_count != 0 || fifo1_count != 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, sched_busy, 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    int n;
    logic [7:0] exp_order [6];
    exp_order = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("post_release_idle", sched_busy, 0);
    busy_len = 10;
    push(0, 8'hA5);
    wait_send("single_send");
    chk("single_data", tx_data, 8'hA5);
    chk("single_grant", grant_id, 0);
    wait_idle("single_idle");
    do_reset();
    busy_len = 3;
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'(8'h10 + i); req1_data = 8'(8'h20 + i);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("rr_idle");
    chk("rr_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) chk("rr_order", log_q[i], exp_order[i]);
    busy_len = 30;
    log_q.delete();
    push(1, 8'h77);
    wait_send("full_first_send");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(0, 8'(8'h80 + i));
    chk("full_cnt", fifo0_count, 4);
    chk("full_rdy", req0_ready, 0);
    repeat (5) @(posedge clk);
    #1 chk("full_rdy_hold", req0_ready, 0);
    push(0, 8'h84);
    chk("full_after_pop", log_q.size(), 2);
    chk("full_cnt_after", fifo0_count, 4);
    busy_len = 2;
    wait_idle("full_idle");
    stall = 1'b1;
    push(0, 8'h5A);
    push(0, 8'h5B);
    wait_send("to_send");
    @(posedge clk); #1 stall = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
    chk("to_cycles", n, BT);
    chk("to_idle", sched_busy, 0);
    wait_send("to_next_send");
    chk("to_next_data", tx_data, 8'h5B);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", err_timeout, 0);
    wait_idle("to_idle_end");
    busy_len = 10;
    push(1, 8'h44);
    wait_send("mid_send");
    @(posedge clk); #1;
    push(0, 8'h55);
    push(0, 8'h66);
    chk("mid_busy", sched_busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_send", tx_send, 0);
    chk("mid_rst_cnt0", fifo0_count, 0);
    chk("mid_rst_cnt1", fifo1_count, 0);
    chk("mid_rst_busy", sched_busy, 0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    push(0, 8'h3C);
    wait_send("post_rst_send");
    chk("post_rst_data", tx_data, 8'h3C);
    chk("post_rst_grant", grant_id, 0);
    wait_idle("post_rst_idle");
    for (int i = 0; i < 2000; i++) begin
      req0_valid = $urandom_range(0, 2) == 0;
      req1_valid = $urandom_range(0, 2) == 0;
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      busy_len   = $urandom_range(1, 8);
      stall      = $urandom_range(0, 9) == 0;
      err_clr    = $urandom_range(0, 15) == 0;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0; err_clr = 1'b0;
    wait_idle("rand_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
